regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have exactly one parameter: DEPTH, default 2, per-requester queue entries (power of two, >=2).
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low, with ports named as below.
REQ-003 i_clk  in  1  clock; all state updates on rising edge.
REQ-004 i_rst  in  1  asynchronous active-low reset.
REQ-005 i_a_valid  in  1  ALU writeback request valid.
REQ-006 i_a_rd_num  in  5  ALU destination register.
REQ-007 i_a_rd  in  32  ALU writeback value.
REQ-008 o_a_ready  out  1  ALU queue can accept.
REQ-009 i_b_valid  in  1  load-unit writeback request valid.
REQ-010 i_b_rd_num  in  5  load destination register.
REQ-011 i_b_rd  in  32  load writeback value.
REQ-012 o_b_ready  out  1  load queue can accept.
REQ-013 o_reg_op  out  1  register-file write enable.
REQ-014 o_w_rd_num  out  5  register-file write index.
REQ-015 o_w_rd  out  32  register-file write data.
REQ-016 i_q_num_1  in  5  decode rs1 index for hazard query.
REQ-017 i_q_num_2  in  5  decode rs2 index for hazard query.
REQ-018 o_busy_1  out  1  rs1 has a write still pending.
REQ-019 o_busy_2  out  1  rs2 has a write still pending.

Function
REQ-020 A request SHALL transfer on a rising edge where valid and ready are both high.
REQ-021 Each requester SHALL own a FIFO of DEPTH entries {rd_num, rd}; ready SHALL be high iff that FIFO is not full, derived from registered state only.
REQ-022 A transfer with rd_num==0 SHALL be accepted but not enqueued.
REQ-023 Each cycle where at least one FIFO is non-empty, exactly one head SHALL be popped into the output register.
REQ-024 Arbitration SHALL be round-robin: when both are non-empty, grant the requester not granted last; a lone non-empty FIFO is always granted.
REQ-025 The output register SHALL drive o_reg_op=1 with the popped entry for exactly one cycle, one cycle after the pop (enqueue-to-write latency 2 cycles when uncontended); otherwise o_reg_op=0 and o_w_rd_num/o_w_rd hold their last values.
REQ-026 A pop and push on the same FIFO in one cycle SHALL both occur; occupancy is unchanged.
REQ-027 FIFO pointers SHALL wrap modulo DEPTH; occupancy counter width clog2(DEPTH)+1.
REQ-028 o_busy_n SHALL be high iff i_q_num_n!=0 and matches rd_num of any valid FIFO entry or the output register while o_reg_op=1; combinational from registered state and the query input.
REQ-029 Ordering between A and B to the same rd is not enforced; decode SHALL stall on o_busy to avoid it.

Reset
REQ-030 On i_rst low, immediately: both FIFOs empty, o_a_ready=o_b_ready=1, o_reg_op=0, o_w_rd_num=0, o_w_rd=0, o_busy_1=o_busy_2=0, last-grant=B.
REQ-031 Reset mid-operation SHALL discard all queued and in-flight writes; no write is issued in the cycle after deassertion.

Configuration
REQ-032 With macro WB_ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority to B (load) whenever B is non-empty; without it, REQ-024 round-robin applies.

Verification
REQ-033 After reset, A pushes (x5, 0x11) -> o_reg_op=1, o_w_rd_num=5, o_w_rd=0x11 exactly two edges later, one cycle only.
REQ-034 A and B push (x1, 0xA) and (x2, 0xB) in the same cycle -> writes x1 then x2 on consecutive cycles (last-grant=B at reset); with WB_ARB_FIXED_PRIO_EN, x2 then x1.
REQ-035 Hold i_b_valid=1 for 3 cycles with A idle, DEPTH=2 -> o_b_ready stays 1 because each entry is popped the cycle after it is enqueued; all 3 writes retire in order.
REQ-036 Push (x0, 0xFF) on A -> o_a_ready stays 1, no o_reg_op pulse, o_busy never asserts for i_q_num_1=0.
REQ-037 Push (x7, 0x3) on B, i_q_num_2=7 -> o_busy_2=1 from the edge after acceptance through the o_reg_op cycle, 0 the next cycle.
REQ-038 Fill both FIFOs, assert i_rst low mid-cycle -> outputs go to reset values without a clock edge; no writes follow deassertion.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: two requester FIFOs (ALU = A, load = B) feeding one write port.
// Default arbitration is round-robin; defining WB_ARB_FIXED_PRIO_EN gives B fixed priority.
module regfile_wb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_a_valid,
  input  logic [4:0]  i_a_rd_num,
  input  logic [31:0] i_a_rd,
  output logic        o_a_ready,
  input  logic        i_b_valid,
  input  logic [4:0]  i_b_rd_num,
  input  logic [31:0] i_b_rd,
  output logic        o_b_ready,
  output logic        o_reg_op,
  output logic [4:0]  o_w_rd_num,
  output logic [31:0] o_w_rd,
  input  logic [4:0]  i_q_num_1,
  input  logic [4:0]  i_q_num_2,
  output logic        o_busy_1,
  output logic        o_busy_2
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Index 0 is requester A (ALU), index 1 is requester B (load).
  logic [36:0]            mem_q [2][DEPTH];
  logic [1:0][PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic                   last_b_q, last_b_d;
  logic                   reg_op_q, reg_op_d;
  logic [4:0]             w_rd_num_q, w_rd_num_d;
  logic [31:0]            w_rd_q, w_rd_d;

  logic [1:0]             in_vld_s, ready_s, push_s, pop_s, nonempty_s;
  logic [1:0][4:0]        in_num_s;
  logic [1:0][31:0]       in_data_s;
  logic                   gnt_b_s;
  logic [36:0]            head_s;
  logic [PTR_W-1:0]       idx_s;
  logic                   busy_1_s, busy_2_s;

  // Requester steering, occupancy flags and arbitration.
  always_comb begin
    in_vld_s   = {i_b_valid, i_a_valid};
    in_num_s   = {i_b_rd_num, i_a_rd_num};
    in_data_s  = {i_b_rd, i_a_rd};
    for (int r = 0; r < 2; r++) begin
      ready_s[r]    = (cnt_q[r] != CNT_W'(DEPTH));
      nonempty_s[r] = (cnt_q[r] != {CNT_W{1'b0}});
      // rd_num 0 handshakes normally but is never queued.
      push_s[r]     = in_vld_s[r] & ready_s[r] & (in_num_s[r] != 5'd0);
    end
`ifdef WB_ARB_FIXED_PRIO_EN
    gnt_b_s = nonempty_s[1];
`else
    gnt_b_s = nonempty_s[1] & (~nonempty_s[0] | ~last_b_q);
`endif
    pop_s[0] = nonempty_s[0] & ~gnt_b_s;
    pop_s[1] = gnt_b_s;
    head_s   = mem_q[gnt_b_s][rptr_q[gnt_b_s]];
  end

  // Pointer, occupancy and output-register next state.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q;
    last_b_d   = last_b_q;
    reg_op_d   = 1'b0;
    w_rd_num_d = w_rd_num_q;
    w_rd_d     = w_rd_q;
    for (int r = 0; r < 2; r++) begin
      if (push_s[r]) begin
        wptr_d[r] = wptr_q[r] + PTR_W'(1);
      end else begin
        wptr_d[r] = wptr_q[r];
      end
      if (pop_s[r]) begin
        rptr_d[r] = rptr_q[r] + PTR_W'(1);
      end else begin
        rptr_d[r] = rptr_q[r];
      end
      case ({push_s[r], pop_s[r]})
        2'b10:   cnt_d[r] = cnt_q[r] + CNT_W'(1);
        2'b01:   cnt_d[r] = cnt_q[r] - CNT_W'(1);
        default: cnt_d[r] = cnt_q[r];
      endcase
    end
    if (|nonempty_s) begin
      last_b_d   = gnt_b_s;
      reg_op_d   = 1'b1;
      w_rd_num_d = head_s[36:32];
      w_rd_d     = head_s[31:0];
    end else begin
      last_b_d   = last_b_q;
    end
  end

  // State registers; reset discards all queued and in-flight writes.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int r = 0; r < 2; r++) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem_q[r][i] <= 37'd0;
        end
      end
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      last_b_q   <= 1'b1;
      reg_op_q   <= 1'b0;
      w_rd_num_q <= 5'd0;
      w_rd_q     <= 32'd0;
    end else begin
      for (int r = 0; r < 2; r++) begin
        if (push_s[r]) begin
          mem_q[r][wptr_q[r]] <= {in_num_s[r], in_data_s[r]};
        end
      end
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      last_b_q   <= last_b_d;
      reg_op_q   <= reg_op_d;
      w_rd_num_q <= w_rd_num_d;
      w_rd_q     <= w_rd_d;
    end
  end

  // Hazard query: live FIFO entries plus the write currently being issued.
  always_comb begin
    busy_1_s = 1'b0;
    busy_2_s = 1'b0;
    idx_s    = {PTR_W{1'b0}};
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        idx_s = rptr_q[r] + PTR_W'(i);
        if (CNT_W'(i) < cnt_q[r]) begin
          if (mem_q[r][idx_s][36:32] == i_q_num_1) busy_1_s = 1'b1;
          if (mem_q[r][idx_s][36:32] == i_q_num_2) busy_2_s = 1'b1;
        end else begin
          idx_s = idx_s;
        end
      end
    end
    if (reg_op_q) begin
      if (w_rd_num_q == i_q_num_1) busy_1_s = 1'b1;
      if (w_rd_num_q == i_q_num_2) busy_2_s = 1'b1;
    end else begin
      idx_s = idx_s;
    end
    busy_1_s = busy_1_s & (i_q_num_1 != 5'd0);
    busy_2_s = busy_2_s & (i_q_num_2 != 5'd0);
  end

  assign o_a_ready  = ready_s[0];
  assign o_b_ready  = ready_s[1];
  assign o_reg_op   = reg_op_q;
  assign o_w_rd_num = w_rd_num_q;
  assign o_w_rd     = w_rd_q;
  assign o_busy_1   = busy_1_s;
  assign o_busy_2   = busy_2_s;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (DEPTH=2); expectations follow WB_ARB_FIXED_PRIO_EN if defined.
module tb_regfile_wb_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_a_valid = 1'b0, i_b_valid = 1'b0;
  logic [4:0]  i_a_rd_num = 5'd0, i_b_rd_num = 5'd0;
  logic [31:0] i_a_rd = 32'd0, i_b_rd = 32'd0;
  logic [4:0]  i_q_num_1 = 5'd0, i_q_num_2 = 5'd0;
  logic        o_a_ready, o_b_ready, o_reg_op, o_busy_1, o_busy_2;
  logic [4:0]  o_w_rd_num;
  logic [31:0] o_w_rd;
  int          nvec = 0;
  int          nerr = 0;

  regfile_wb_arbiter #(.DEPTH(2)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_a_valid(i_a_valid), .i_a_rd_num(i_a_rd_num), .i_a_rd(i_a_rd), .o_a_ready(o_a_ready),
    .i_b_valid(i_b_valid), .i_b_rd_num(i_b_rd_num), .i_b_rd(i_b_rd), .o_b_ready(o_b_ready),
    .o_reg_op(o_reg_op), .o_w_rd_num(o_w_rd_num), .o_w_rd(o_w_rd),
    .i_q_num_1(i_q_num_1), .i_q_num_2(i_q_num_2), .o_busy_1(o_busy_1), .o_busy_2(o_busy_2)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_a_ready"}, 32'(o_a_ready), 32'd1);
    chk({tag, "_b_ready"}, 32'(o_b_ready), 32'd1);
    chk({tag, "_reg_op"}, 32'(o_reg_op), 32'd0);
    chk({tag, "_w_rd_num"}, 32'(o_w_rd_num), 32'd0);
    chk({tag, "_w_rd"}, o_w_rd, 32'd0);
    chk({tag, "_busy_1"}, 32'(o_busy_1), 32'd0);
    chk({tag, "_busy_2"}, 32'(o_busy_2), 32'd0);
  endtask

  task automatic pulse_reset();
    #2 i_rst = 1'b0;
    #2 i_rst = 1'b1;
  endtask

  initial begin
    #1 i_rst = 1'b0;
    i_q_num_1 = 5'd5;
    i_q_num_2 = 5'd2;
    #1 chk_reset("rst");
    step();
    step();
    i_rst = 1'b1;

    // Single ALU write: two edges to o_reg_op, one cycle wide.
    i_a_valid = 1'b1; i_a_rd_num = 5'd5; i_a_rd = 32'h11;
    step();
    i_a_valid = 1'b0;
    chk("lat_e1_op", 32'(o_reg_op), 32'd0);
    chk("lat_e1_busy", 32'(o_busy_1), 32'd1);
    step();
    chk("lat_e2_op", 32'(o_reg_op), 32'd1);
    chk("lat_e2_num", 32'(o_w_rd_num), 32'd5);
    chk("lat_e2_rd", o_w_rd, 32'h11);
    step();
    chk("lat_e3_op", 32'(o_reg_op), 32'd0);
    chk("lat_e3_hold_num", 32'(o_w_rd_num), 32'd5);
    chk("lat_e3_hold_rd", o_w_rd, 32'h11);
    chk("lat_e3_busy", 32'(o_busy_1), 32'd0);

    // Simultaneous A/B after reset.
    pulse_reset();
    step();
    i_a_valid = 1'b1; i_a_rd_num = 5'd1; i_a_rd = 32'hA;
    i_b_valid = 1'b1; i_b_rd_num = 5'd2; i_b_rd = 32'hB;
    step();
    i_a_valid = 1'b0; i_b_valid = 1'b0;
    chk("arb_e1_op", 32'(o_reg_op), 32'd0);
    chk("arb_e1_busy2", 32'(o_busy_2), 32'd1);
    step();
    chk("arb_w1_op", 32'(o_reg_op), 32'd1);
`ifdef WB_ARB_FIXED_PRIO_EN
    chk("arb_w1_num", 32'(o_w_rd_num), 32'd2);
    chk("arb_w1_rd", o_w_rd, 32'hB);
`else
    chk("arb_w1_num", 32'(o_w_rd_num), 32'd1);
    chk("arb_w1_rd", o_w_rd, 32'hA);
`endif
    step();
    chk("arb_w2_op", 32'(o_reg_op), 32'd1);
`ifdef WB_ARB_FIXED_PRIO_EN
    chk("arb_w2_num", 32'(o_w_rd_num), 32'd1);
    chk("arb_w2_rd", o_w_rd, 32'hA);
`else
    chk("arb_w2_num", 32'(o_w_rd_num), 32'd2);
    chk("arb_w2_rd", o_w_rd, 32'hB);
`endif
    step();
    chk("arb_idle_op", 32'(o_reg_op), 32'd0);

    // Back-to-back B stream never back-pressures with DEPTH=2.
    for (int k = 0; k < 3; k++) begin
      i_b_valid = 1'b1; i_b_rd_num = 5'(10 + k); i_b_rd = 32'(256 + k);
      chk("strm_b_ready", 32'(o_b_ready), 32'd1);
      step();
      if (k > 0) begin
        chk("strm_op", 32'(o_reg_op), 32'd1);
        chk("strm_num", 32'(o_w_rd_num), 32'(9 + k));
        chk("strm_rd", o_w_rd, 32'(255 + k));
      end
    end
    i_b_valid = 1'b0;
    chk("strm_b_ready_end", 32'(o_b_ready), 32'd1);
    step();
    chk("strm_last_op", 32'(o_reg_op), 32'd1);
    chk("strm_last_num", 32'(o_w_rd_num), 32'd12);
    step();
    chk("strm_idle_op", 32'(o_reg_op), 32'd0);

    // Write to x0 is accepted and dropped.
    i_q_num_1 = 5'd0;
    i_a_valid = 1'b1; i_a_rd_num = 5'd0; i_a_rd = 32'hFF;
    chk("x0_ready", 32'(o_a_ready), 32'd1);
    step();
    i_a_valid = 1'b0;
    chk("x0_e1_op", 32'(o_reg_op), 32'd0);
    chk("x0_e1_busy", 32'(o_busy_1), 32'd0);
    chk("x0_e1_ready", 32'(o_a_ready), 32'd1);
    step();
    chk("x0_e2_op", 32'(o_reg_op), 32'd0);
    chk("x0_e2_busy", 32'(o_busy_1), 32'd0);
    step();
    chk("x0_e3_op", 32'(o_reg_op), 32'd0);

    // Busy window for a single B write to x7.
    i_q_num_1 = 5'd7; i_q_num_2 = 5'd7;
    i_b_valid = 1'b1; i_b_rd_num = 5'd7; i_b_rd = 32'h3;
    chk("busy_pre", 32'(o_busy_2), 32'd0);
    step();
    i_b_valid = 1'b0;
    chk("busy_e1_b2", 32'(o_busy_2), 32'd1);
    chk("busy_e1_b1", 32'(o_busy_1), 32'd1);
    chk("busy_e1_op", 32'(o_reg_op), 32'd0);
    step();
    chk("busy_e2_b2", 32'(o_busy_2), 32'd1);
    chk("busy_e2_op", 32'(o_reg_op), 32'd1);
    chk("busy_e2_num", 32'(o_w_rd_num), 32'd7);
    chk("busy_e2_rd", o_w_rd, 32'h3);
    step();
    chk("busy_e3_b2", 32'(o_busy_2), 32'd0);
    chk("busy_e3_op", 32'(o_reg_op), 32'd0);

    // Fill both queues, then async reset mid-cycle.
    i_q_num_1 = 5'd3; i_q_num_2 = 5'd4;
    i_a_valid = 1'b1; i_a_rd_num = 5'd3; i_a_rd = 32'h30;
    i_b_valid = 1'b1; i_b_rd_num = 5'd4; i_b_rd = 32'h40;
    step();
    step();
    i_a_valid = 1'b0; i_b_valid = 1'b0;
`ifdef WB_ARB_FIXED_PRIO_EN
    chk("fill_a_ready", 32'(o_a_ready), 32'd0);
    chk("fill_b_ready", 32'(o_b_ready), 32'd1);
`else
    chk("fill_a_ready", 32'(o_a_ready), 32'd1);
    chk("fill_b_ready", 32'(o_b_ready), 32'd0);
`endif
    chk("fill_op", 32'(o_reg_op), 32'd1);
    chk("fill_busy1", 32'(o_busy_1), 32'd1);
    chk("fill_busy2", 32'(o_busy_2), 32'd1);
    #2 i_rst = 1'b0;
    #1 chk_reset("midrst");
    #1 i_rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("post_rst_op", 32'(o_reg_op), 32'd0);
      chk("post_rst_busy1", 32'(o_busy_1), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
